// File: rtl/haraka_squeeze_out.sv
// rtl/haraka_squeeze_out.sv - Haraka-S sponge squeeze reader: captures permuted state, streams rate words
module haraka_squeeze_out #(
  parameter int STATE_W = 512,
  parameter int RATE_W  = 256,
  parameter int OUT_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        out_len,
  output logic               perm_req,
  input  logic               state_valid,
  input  logic [STATE_W-1:0] state_in,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int WPB   = RATE_W / OUT_W;
  localparam int IDX_W = $clog2(WPB + 1);
  localparam logic [IDX_W-1:0] WPB_I = IDX_W'(WPB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

  state_t              state, state_d;
  logic [RATE_W-1:0]   rate_buf, rate_d;
  logic [15:0]         remaining, remaining_d, rem_dec;
  logic [IDX_W-1:0]    idx, idx_d, idx_inc;
  logic [OUT_W-1:0]    out_data_d;
  logic                perm_req_d, out_valid_d, out_last_d, busy_d, done_d;

  // Word 0 is the most significant slice of the rate.
  function automatic logic [OUT_W-1:0] word_at(input logic [RATE_W-1:0] r,
                                               input logic [IDX_W-1:0]  i);
    logic [RATE_W-1:0] s;
    s = r << (int'(i) * OUT_W);
    return s[RATE_W-1 -: OUT_W];
  endfunction

  assign idx_inc = idx + IDX_W'(1);
  assign rem_dec = (remaining != 16'd0) ? remaining - 16'd1 : remaining;

  always_comb begin
    state_d     = state;
    rate_d      = rate_buf;
    remaining_d = remaining;
    idx_d       = idx;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    busy_d      = busy;
    perm_req_d  = 1'b0;
    done_d      = 1'b0;
    case (state)
      IDLE: begin
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (start) begin
          if (out_len != 16'd0) begin
            remaining_d = out_len;
            state_d     = REQ;
            perm_req_d  = 1'b1;
            busy_d      = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (state_valid) begin
          rate_d      = state_in[STATE_W-1 -: RATE_W];
          idx_d       = '0;
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_data_d  = state_in[STATE_W-1 -: OUT_W];
          out_last_d  = (remaining == 16'd1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          remaining_d = rem_dec;
          idx_d       = idx_inc;
          if (remaining == 16'd1) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else if (idx_inc == WPB_I) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            perm_req_d  = 1'b1;
            state_d     = REQ;
          end else begin
            out_data_d = word_at(rate_buf, idx_inc);
            out_last_d = (rem_dec == 16'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rate_buf  <= '0;
      remaining <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      perm_req  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      rate_buf  <= rate_d;
      remaining <= remaining_d;
      idx       <= idx_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      perm_req  <= perm_req_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_haraka_squeeze_out.sv
// tb/tb_haraka_squeeze_out.sv - directed self-checking bench for haraka_squeeze_out
module tb_haraka_squeeze_out;

  logic         clk = 1'b0;
  logic         reset, start, state_valid, out_ready;
  logic [15:0]  out_len;
  logic [511:0] state_in;
  logic         perm_req, out_valid, out_last, busy, done;
  logic [63:0]  out_data;

  int checks = 0;
  int failures = 0;
  int perm_cnt = 0;
  int done_cnt = 0;
  int p0, d0;
  logic [63:0] got[$];
  logic        lasts[$];

  localparam logic [511:0] S1 = {64'hA0A0A0A0A0A0A0A0, 64'hB1B1B1B1B1B1B1B1,
                                 64'hC2C2C2C2C2C2C2C2, 64'hD3D3D3D3D3D3D3D3,
                                 {4{64'h5555555555555555}}};
  localparam logic [511:0] S2 = {64'h1111111111111111, 64'h2222222222222222,
                                 64'h3333333333333333, 64'h4444444444444444,
                                 {4{64'hEEEEEEEEEEEEEEEE}}};

  haraka_squeeze_out dut (
    .clk(clk), .reset(reset), .start(start), .out_len(out_len),
    .perm_req(perm_req), .state_valid(state_valid), .state_in(state_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      if (perm_req) perm_cnt++;
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        lasts.push_back(out_last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; out_len = '0; state_valid = 1'b0;
    state_in = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_perm_req", perm_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    tick();

    // 1: single full block
    got.delete(); lasts.delete(); p0 = perm_cnt;
    out_len = 16'd4; start = 1'b1;
    tick(); start = 1'b0;
    check("t1_perm_req_hi", perm_req, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_perm_req_lo", perm_req, 0);
    state_valid = 1'b1; state_in = S1;
    tick(); state_valid = 1'b0;
    check("t1_valid", out_valid, 1);
    check("t1_w0", out_data, 64'hA0A0A0A0A0A0A0A0);
    check("t1_w0_last", out_last, 0);
    tick(); check("t1_w1", out_data, 64'hB1B1B1B1B1B1B1B1);
    tick(); check("t1_w2", out_data, 64'hC2C2C2C2C2C2C2C2);
    tick(); check("t1_w3", out_data, 64'hD3D3D3D3D3D3D3D3);
    check("t1_w3_last", out_last, 1);
    tick();
    check("t1_done", done, 1);
    check("t1_valid_lo", out_valid, 0);
    check("t1_busy_done", busy, 1);
    tick();
    check("t1_done_lo", done, 0);
    check("t1_busy_lo", busy, 0);
    check("t1_perms", perm_cnt - p0, 1);
    check("t1_count", got.size(), 4);

    // 2: two blocks, partial second
    got.delete(); lasts.delete(); p0 = perm_cnt;
    out_len = 16'd6; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    state_valid = 1'b1; state_in = S1;
    tick(); state_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check("t2_perm_req2", perm_req, 1);
    check("t2_valid_gap", out_valid, 0);
    tick();
    state_valid = 1'b1; state_in = S2;
    tick(); state_valid = 1'b0;
    check("t2_w4", out_data, 64'h1111111111111111);
    check("t2_w4_last", out_last, 0);
    tick();
    check("t2_w5", out_data, 64'h2222222222222222);
    check("t2_w5_last", out_last, 1);
    tick();
    check("t2_done", done, 1);
    check("t2_count", got.size(), 6);
    check("t2_q3", got[3], 64'hD3D3D3D3D3D3D3D3);
    check("t2_q3_last", lasts[3], 0);
    check("t2_q5", got[5], 64'h2222222222222222);
    check("t2_q5_last", lasts[5], 1);
    check("t2_perms", perm_cnt - p0, 2);
    tick();

    // 3: backpressure on word 1
    got.delete(); lasts.delete();
    out_len = 16'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    state_valid = 1'b1; state_in = S1;
    tick(); state_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_data", out_data, 64'hB1B1B1B1B1B1B1B1);
    end
    out_ready = 1'b1;
    tick(); check("t3_w2", out_data, 64'hC2C2C2C2C2C2C2C2);
    tick(); tick();
    check("t3_done", done, 1);
    check("t3_count", got.size(), 4);
    check("t3_q1", got[1], 64'hB1B1B1B1B1B1B1B1);
    check("t3_q2", got[2], 64'hC2C2C2C2C2C2C2C2);
    tick();

    // 4: zero-length squeeze
    p0 = perm_cnt;
    out_len = 16'd0; start = 1'b1;
    tick(); start = 1'b0;
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_perm_req", perm_req, 0);
    check("t4_valid", out_valid, 0);
    tick();
    check("t4_done_lo", done, 0);
    check("t4_perms", perm_cnt - p0, 0);

    // 5: reset during word 2, then restart
    out_len = 16'd4; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    state_valid = 1'b1; state_in = S1;
    tick(); state_valid = 1'b0;
    tick(); tick();
    check("t5_pre_w2", out_data, 64'hC2C2C2C2C2C2C2C2);
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_data", out_data, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_last", out_last, 0);
    tick();
    reset = 1'b1;
    tick();
    check("t5_no_done", done_cnt - d0, 0);
    got.delete(); lasts.delete();
    out_len = 16'd2; start = 1'b1;
    tick(); start = 1'b0;
    check("t5_perm_req", perm_req, 1);
    tick();
    state_valid = 1'b1; state_in = S2;
    tick(); state_valid = 1'b0;
    tick();
    check("t5_w1", out_data, 64'h2222222222222222);
    check("t5_w1_last", out_last, 1);
    tick();
    check("t5_done", done, 1);
    check("t5_count", got.size(), 2);
    tick();

    // 6: spurious start and state_valid
    got.delete(); lasts.delete(); p0 = perm_cnt;
    state_valid = 1'b1; state_in = S2;
    tick(); state_valid = 1'b0;
    check("t6_idle_sv_valid", out_valid, 0);
    check("t6_idle_sv_busy", busy, 0);
    out_len = 16'd4; start = 1'b1;
    tick();
    out_len = 16'd9;
    tick(); start = 1'b0;
    state_valid = 1'b1; state_in = S1;
    tick(); state_valid = 1'b0;
    start = 1'b1; state_valid = 1'b1; state_in = S2;
    tick(); start = 1'b0; state_valid = 1'b0;
    check("t6_w1", out_data, 64'hB1B1B1B1B1B1B1B1);
    tick(); tick();
    check("t6_w3_last", out_last, 1);
    check("t6_w3", out_data, 64'hD3D3D3D3D3D3D3D3);
    tick();
    check("t6_done", done, 1);
    check("t6_count", got.size(), 4);
    check("t6_perms", perm_cnt - p0, 1);
    tick();
    check("t6_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
